// File: rtl/channel_to_pulse.sv
`default_nettype none
// ============================================================================
// Module   : channel_to_pulse
// Brief    : Channel consumer that turns each accepted word into a registered
//            data word plus a fixed-width pulse, followed by a holdoff gap.
// Revision : 1.0 - initial release
// ============================================================================
module channel_to_pulse #(
  parameter int N       = 1,
  parameter int PULSE_W = 1,
  parameter int GAP     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d,
  input  logic         in_v,
  output logic         in_a,
  input  logic         enable,
  output logic [N-1:0] data,
  output logic         pulse,
  output logic         busy
);

  localparam int c_max   = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int c_cnt_w = $clog2(c_max + 1);
  localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load   = (GAP > 0) ? c_cnt_w'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic [N-1:0]         r_data;
  logic                 r_pulse;
  logic                 w_accept;

  // Only IDLE can acknowledge, and never while reset is asserted.
  assign w_accept = (r_state == S_IDLE) & in_v & enable & ~reset;
  assign in_a     = w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PULSE;
          w_count_nxt = c_pulse_load;
        end
      end
      S_PULSE: begin
        if (r_count == '0) begin
          if (GAP > 0) begin
            w_state_nxt = S_HOLDOFF;
            w_count_nxt = c_gap_load;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_count == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_data  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pulse <= (w_state_nxt == S_PULSE);
      if (w_accept) begin
        r_data <= in_d;
      end
    end
  end

  assign data  = r_data;
  assign pulse = r_pulse;
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/channel_to_pulse.md
Name: channel_to_pulse

Overview:
- Consumer end of the pulse/channel pair: accepts words from an N-wide Channel and turns each one into a registered data word plus a pulse of configurable width.
- Enforces a configurable holdoff gap so slow, pulse-driven logic (register strobes, low-rate config loads) can consume Channel traffic without its own handshake.
- Never drops a word. Back-pressure is applied by withholding in.a.

Parameters:
- N, 1, data width of the input Channel and the data output.
- PULSE_W, 1, pulse high time in clk cycles; must be >= 1.
- GAP, 0, mandatory low cycles after each pulse before the next word is accepted; must be >= 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in  Channel interface (d: N, v: 1 toward block; a: 1 from block)  N  input Channel (d, v, a).
- enable  input  1  when 0, no new word is accepted; a pulse already in progress completes.
- data  output  N  last accepted word; held until the next accept.
- pulse  output  1  high for PULSE_W cycles per accepted word.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: it acts only at a posedge of clk with reset=1.
- Reset values: state=IDLE, data=0, pulse=0, busy=0, counter=0.
- in.a is forced to 0 combinationally while reset=1.
- States: IDLE, PULSE, HOLDOFF. One down-counter, width $clog2(max(PULSE_W,GAP)+1).
- IDLE:
  - in.a = in.v & enable, combinational. This is the only state that can ack.
  - On accept (in.v & in.a at a posedge): data <= in.d, counter <= PULSE_W-1, state -> PULSE.
- PULSE:
  - pulse=1, in.a=0.
  - counter==0 and GAP>0: counter <= GAP-1, state -> HOLDOFF.
  - counter==0 and GAP==0: state -> IDLE.
  - Otherwise: counter decrements.
- HOLDOFF:
  - pulse=0, in.a=0.
  - counter==0: state -> IDLE. Otherwise counter decrements.
- pulse and data are registered outputs.
- Latency: accept at edge t gives pulse=1 and data=word during cycles t+1 .. t+PULSE_W.
- Throughput: accepts are spaced at least PULSE_W+GAP+1 cycles apart. With in.v held high continuously the spacing is exactly that.
- data changes only on an accept; it stays stable for the whole pulse and after it.
- busy = (state != IDLE).
- enable falling during PULSE or HOLDOFF does not shorten the sequence; it only blocks the next accept in IDLE.
- enable=0 in IDLE: in.a=0, in.v may stay high indefinitely with no state change.
- in.v deasserting with no accept is legal; the block takes no action.
- in.d is sampled only at the accept edge. Values of in.d outside the accept edge are don't-care.
- Reset mid-operation: at the next posedge with reset=1, pulse drops to 0, data clears, state -> IDLE. The interrupted word is not re-emitted.
- Reset and an accept on the same edge: reset wins and no word is consumed, since in.a=0 during reset.

Test Plan:
- Single word (N=8, PULSE_W=1, GAP=0): in.d=0xA5, in.v for 1 cycle with enable=1 -> in.a=1 that cycle; next cycle pulse=1, data=0xA5; the cycle after, pulse=0 and data stays 0xA5.
- Streaming (PULSE_W=3, GAP=2): in.v held high with words 1,2,3 -> acks exactly 6 cycles apart; each pulse is 3 cycles high, then 3 low including the accept cycle; data steps 1,2,3.
- Enable gating: enable=0 with in.v=1 for 10 cycles -> in.a=0, pulse=0, busy=0. Raise enable -> ack that same cycle, pulse on the next.
- Enable dropped mid-pulse (PULSE_W=4): deassert enable on the 2nd pulse cycle -> pulse still 4 cycles high and HOLDOFF completes; no further ack until enable=1.
- Reset mid-pulse (PULSE_W=4): assert reset on the 2nd pulse cycle -> next edge gives pulse=0, data=0, busy=0, in.a=0 while reset=1. After release with in.v=1, a new ack occurs on the first non-reset cycle.
- Randomized in.v/enable against a reference model -> each accepted word appears exactly once on data, with exactly PULSE_W pulse-high cycles, and minimum ack spacing PULSE_W+GAP+1.
